// File: rtl/mips_control_fsm.sv
`default_nettype none
// ============================================================================
// mips_control_fsm : multi-cycle MIPS-subset control unit
//                    (FETCH/DECODE/EXEC/MEM/WB) with retired-instruction count.
// Revision 1.0
// ============================================================================
module mips_control_fsm #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      instr,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic             zero,
   output logic [4:0]       rd,
   output logic [4:0]       rs,
   output logic [4:0]       rt,
   output logic [15:0]      imm16,
   output logic [25:0]      jumpTarget,
   output logic             regDst,
   output logic             regWr,
   output logic             ALUSrc,
   output logic             memWr,
   output logic             memToReg,
   output logic             jal,
   output logic [3:0]       ALUcntrl,
   output logic             pcWr,
   output logic [1:0]       pcSrc,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_XOR = 4'd2;
   localparam logic [3:0] ALU_SLT = 4'd3;

   localparam logic [1:0] PC_SEQ    = 2'd0;
   localparam logic [1:0] PC_BRANCH = 2'd1;
   localparam logic [1:0] PC_JUMP   = 2'd2;
   localparam logic [1:0] PC_REG    = 2'd3;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   typedef enum logic [3:0] {
      C_RALU = 4'd0,
      C_JR   = 4'd1,
      C_LW   = 4'd2,
      C_SW   = 4'd3,
      C_XORI = 4'd4,
      C_BNE  = 4'd5,
      C_J    = 4'd6,
      C_JAL  = 4'd7,
      C_ILL  = 4'd8
   } cls_t;

   state_t      state;
   state_t      next_state;
   logic [31:0] ir;
   cls_t        cls;
   logic [3:0]  alu_r;

   assign rs          = ir[25:21];
   assign rt          = ir[20:16];
   assign rd          = ir[15:11];
   assign imm16       = ir[15:0];
   assign jumpTarget  = ir[25:0];
   assign instr_ready = (state == S_FETCH) && !reset;

   // Instruction classification from the latched IR
   always_comb begin
      cls   = C_ILL;
      alu_r = ALU_ADD;
      case (ir[31:26])
         6'h00: begin
            case (ir[5:0])
               6'h20:   begin cls = C_RALU; alu_r = ALU_ADD; end
               6'h22:   begin cls = C_RALU; alu_r = ALU_SUB; end
               6'h2A:   begin cls = C_RALU; alu_r = ALU_SLT; end
               6'h08:   cls = C_JR;
               default: cls = C_ILL;
            endcase
         end
         6'h23:   cls = C_LW;
         6'h2B:   cls = C_SW;
         6'h0E:   cls = C_XORI;
         6'h05:   cls = C_BNE;
         6'h02:   cls = C_J;
         6'h03:   cls = C_JAL;
         default: cls = C_ILL;
      endcase
   end

   always_comb begin
      next_state = state;
      regDst     = 1'b0;
      regWr      = 1'b0;
      ALUSrc     = 1'b0;
      memWr      = 1'b0;
      memToReg   = 1'b0;
      jal        = 1'b0;
      ALUcntrl   = ALU_ADD;
      pcWr       = 1'b0;
      pcSrc      = PC_SEQ;
      illegal    = 1'b0;
      case (state)
         S_FETCH: begin
            if (instr_valid) next_state = S_DECODE;
         end
         S_DECODE: begin
            case (cls)
               C_J: begin
                  pcWr       = 1'b1;
                  pcSrc      = PC_JUMP;
                  next_state = S_FETCH;
               end
               C_JAL: begin
                  pcWr       = 1'b1;
                  pcSrc      = PC_JUMP;
                  regWr      = 1'b1;
                  jal        = 1'b1;
                  next_state = S_FETCH;
               end
               C_ILL: begin
                  illegal    = 1'b1;
                  pcWr       = 1'b1;
                  next_state = S_FETCH;
               end
               default: next_state = S_EXEC;
            endcase
         end
         S_EXEC: begin
            case (cls)
               C_JR: begin
                  pcWr       = 1'b1;
                  pcSrc      = PC_REG;
                  next_state = S_FETCH;
               end
               C_BNE: begin
                  ALUcntrl   = ALU_SUB;
                  pcWr       = 1'b1;
                  pcSrc      = zero ? PC_SEQ : PC_BRANCH;
                  next_state = S_FETCH;
               end
               C_RALU: begin
                  ALUcntrl   = alu_r;
                  next_state = S_WB;
               end
               C_XORI: begin
                  ALUSrc     = 1'b1;
                  ALUcntrl   = ALU_XOR;
                  next_state = S_WB;
               end
               C_LW, C_SW: begin
                  ALUSrc     = 1'b1;
                  next_state = S_MEM;
               end
               default: next_state = S_FETCH;
            endcase
         end
         S_MEM: begin
            case (cls)
               C_SW: begin
                  memWr      = 1'b1;
                  pcWr       = 1'b1;
                  next_state = S_FETCH;
               end
               C_LW: begin
                  // keep the address stable while memory is read
                  ALUSrc     = 1'b1;
                  next_state = S_WB;
               end
               default: next_state = S_FETCH;
            endcase
         end
         S_WB: begin
            next_state = S_FETCH;
            case (cls)
               C_RALU: begin
                  ALUcntrl = alu_r;
                  regDst   = 1'b1;
                  regWr    = 1'b1;
                  pcWr     = 1'b1;
               end
               C_XORI: begin
                  regWr    = 1'b1;
                  pcWr     = 1'b1;
               end
               C_LW: begin
                  memToReg = 1'b1;
                  regWr    = 1'b1;
                  pcWr     = 1'b1;
               end
               default: ;
            endcase
         end
         default: next_state = S_FETCH;
      endcase
      // An in-flight instruction must not commit anything during reset
      if (reset) begin
         regDst   = 1'b0;
         regWr    = 1'b0;
         ALUSrc   = 1'b0;
         memWr    = 1'b0;
         memToReg = 1'b0;
         jal      = 1'b0;
         ALUcntrl = ALU_ADD;
         pcWr     = 1'b0;
         pcSrc    = PC_SEQ;
         illegal  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_FETCH;
         ir      <= 32'd0;
         retired <= '0;
      end else begin
         state <= next_state;
         if (state == S_FETCH && instr_valid) ir <= instr;
         if (pcWr && !illegal) retired <= retired + 1'b1;
      end
   end

endmodule
`default_nettype wire
